// File: rtl/sm_dbg_ctrl.sv
// Run-control and debug sequencer for the pipelined schoolMIPS core.
// Gates the core clock enable to run, halt or step the core, stops it on a
// fetch-address breakpoint, and streams the register file out over a
// valid/ready channel while the core is halted.
module sm_dbg_ctrl #(
  parameter int unsigned STEP_W       = 16,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       im_addr,
  output logic              cpu_en,
  output logic [4:0]        reg_addr,
  input  logic [31:0]       reg_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [4:0]        dump_idx,
  output logic [31:0]       dump_data,
  output logic              halted,
  output logic              bp_hit,
  output logic              cmd_err,
  output logic [31:0]       cycle_cnt
);

  typedef enum logic [2:0] {
    S_HALT,
    S_RUN,
    S_STEP,
    S_DUMP_RD,
    S_DUMP_WAIT
  } state_t;

  typedef enum logic [1:0] {
    OP_RUN  = 2'b00,
    OP_HALT = 2'b01,
    OP_STEP = 2'b10,
    OP_DUMP = 2'b11
  } op_t;

  localparam state_t RST_STATE = RUN_ON_RESET ? S_RUN : S_HALT;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_left_q, step_left_d;
  logic                bp_skip_q, bp_skip_d;
  logic                bp_hit_q, bp_hit_d;
  logic                cmd_err_q, cmd_err_d;
  logic [31:0]         cycle_cnt_q, cycle_cnt_d;
  logic                dump_valid_q, dump_valid_d;
  logic [4:0]          dump_idx_q, dump_idx_d;
  logic [31:0]         dump_data_q, dump_data_d;

  op_t  op;
  logic cmd_acc;
  logic bp_match;
  logic core_active;

  assign op          = op_t'(cmd_op);
  assign core_active = (state_q == S_RUN) || (state_q == S_STEP);
  assign bp_match    = bp_en && (im_addr == bp_addr) && !bp_skip_q;
  assign cpu_en      = core_active && !bp_match;
  assign cmd_ready   = (state_q == S_HALT) || core_active;
  assign cmd_acc     = cmd_valid && cmd_ready;

  assign halted      = (state_q == S_HALT);
  assign bp_hit      = bp_hit_q;
  assign cmd_err     = cmd_err_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign dump_valid  = dump_valid_q;
  assign dump_idx    = dump_idx_q;
  assign dump_data   = dump_data_q;
  // The debug read port follows the dump index; it is 0 out of reset.
  assign reg_addr    = dump_idx_q;

  // Next-state and command handling for the run-control FSM.
  // A breakpoint hit is applied last so it overrides step completion and
  // any command accepted in the same cycle.
  always_comb begin
    state_d     = state_q;
    step_left_d = step_left_q;
    bp_skip_d   = bp_skip_q;
    bp_hit_d    = bp_hit_q;
    cmd_err_d   = 1'b0;

    // The skip flag only has to cover the first enabled cycle after a resume.
    if (cpu_en) begin
      bp_skip_d = 1'b0;
    end

    unique case (state_q)
      S_HALT: begin
        if (cmd_acc) begin
          unique case (op)
            OP_RUN: begin
              state_d   = S_RUN;
              bp_hit_d  = 1'b0;
              bp_skip_d = 1'b1;
            end
            OP_STEP: begin
              bp_hit_d = 1'b0;
              if (cmd_arg != '0) begin
                step_left_d = cmd_arg;
                state_d     = S_STEP;
                bp_skip_d   = 1'b1;
              end
            end
            OP_DUMP: begin
              state_d = S_DUMP_RD;
            end
            default: ;
          endcase
        end
      end

      S_RUN: begin
        if (cmd_acc) begin
          unique case (op)
            OP_HALT: state_d   = S_HALT;
            OP_RUN:  bp_hit_d  = 1'b0;
            default: cmd_err_d = 1'b1;
          endcase
        end
        if (bp_match) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b1;
        end
      end

      S_STEP: begin
        if (cpu_en) begin
          step_left_d = step_left_q - STEP_W'(1);
          if (step_left_q == STEP_W'(1)) begin
            state_d = S_HALT;
          end
        end
        if (cmd_acc) begin
          if (op == OP_HALT) begin
            state_d = S_HALT;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        if (bp_match) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b1;
        end
      end

      S_DUMP_RD: begin
        state_d = S_DUMP_WAIT;
      end

      S_DUMP_WAIT: begin
        if (dump_valid_q && dump_ready) begin
          state_d = (dump_idx_q == 5'd31) ? S_HALT : S_DUMP_RD;
        end
      end

      default: state_d = S_HALT;
    endcase
  end

  // Dump datapath and cycle counter.
  always_comb begin
    cycle_cnt_d  = cycle_cnt_q + 32'(cpu_en);
    dump_valid_d = dump_valid_q;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;

    unique case (state_q)
      S_HALT: begin
        if (cmd_acc && (op == OP_DUMP)) begin
          dump_idx_d = '0;
        end
      end
      S_DUMP_RD: begin
        dump_data_d  = reg_data;
        dump_valid_d = 1'b1;
      end
      S_DUMP_WAIT: begin
        if (dump_valid_q && dump_ready) begin
          dump_valid_d = 1'b0;
          if (dump_idx_q != 5'd31) begin
            dump_idx_d = dump_idx_q + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset is asynchronous and active-high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= RST_STATE;
      step_left_q  <= '0;
      bp_skip_q    <= 1'b0;
      bp_hit_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
      cycle_cnt_q  <= '0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      step_left_q  <= step_left_d;
      bp_skip_q    <= bp_skip_d;
      bp_hit_q     <= bp_hit_d;
      cmd_err_q    <= cmd_err_d;
      cycle_cnt_q  <= cycle_cnt_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
    end
  end

endmodule

// File: tb/tb_sm_dbg_ctrl.sv
// Testbench for sm_dbg_ctrl: a simple core model (PC advancing by 4 per
// enabled cycle, static register file) driven by directed and randomized
// run/halt/step/breakpoint/dump sequences.
module tb_sm_dbg_ctrl;
  localparam int unsigned STEP_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;
  logic              bp_en;
  logic [31:0]       bp_addr;
  logic [31:0]       pc;
  logic              cpu_en;
  logic [4:0]        reg_addr;
  logic [31:0]       reg_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [4:0]        dump_idx;
  logic [31:0]       dump_data;
  logic              halted;
  logic              bp_hit;
  logic              cmd_err;
  logic [31:0]       cycle_cnt;

  logic [31:0] regs [32];
  logic        pc_ld;
  logic [31:0] pc_ld_val;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt;

  localparam logic [1:0] RUN = 2'b00, HALT = 2'b01, STEP = 2'b10, DUMP = 2'b11;

  sm_dbg_ctrl #(.STEP_W(STEP_W), .RUN_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .bp_en(bp_en), .bp_addr(bp_addr), .im_addr(pc),
    .cpu_en(cpu_en), .reg_addr(reg_addr), .reg_data(reg_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .halted(halted), .bp_hit(bp_hit), .cmd_err(cmd_err), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Core model: fetch PC advances one instruction per enabled cycle.
  always @(posedge clk or posedge rst_n) begin
    if (rst_n)       pc <= '0;
    else if (pc_ld)  pc <= pc_ld_val;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  assign reg_data = regs[reg_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [STEP_W-1:0] arg);
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    chkb("cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    cmd_arg   = STEP_W'($urandom);
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_ld_val = v;
    pc_ld     = 1'b1;
    tick();
    pc_ld     = 1'b0;
  endtask

  task automatic run_until_halt(input int unsigned bound, output int unsigned en);
    en = 0;
    for (int i = 0; i < int'(bound) && !halted; i++) begin
      if (cpu_en) en++;
      tick();
    end
    chkb("halt_reached", halted, 1'b1);
  endtask

  // Consume dump words until stop_at words have been taken or the bound runs out.
  task automatic dump_words(input bit rand_ready, input int unsigned stop_at, output int unsigned got);
    logic        held, toggle;
    logic [31:0] held_data;
    logic [4:0]  held_idx;
    got = 0; held = 1'b0; toggle = 1'b1;
    held_data = '0; held_idx = '0;
    for (int i = 0; i < 400 && got < stop_at; i++) begin
      chkb("dump_cmd_ready", cmd_ready, 1'b0);
      chkb("dump_cpu_en", cpu_en, 1'b0);
      if (held) begin
        chkb("held_valid", dump_valid, 1'b1);
        chk("held_data", dump_data, held_data);
        chk("held_idx", 32'(dump_idx), 32'(held_idx));
      end
      dump_ready = rand_ready ? 1'($urandom) : toggle;
      toggle = ~toggle;
      held = 1'b0;
      if (dump_valid) begin
        if (dump_ready) begin
          chk("dump_idx", 32'(dump_idx), 32'(got));
          chk("dump_data", dump_data, regs[got[4:0]]);
          got++;
        end else begin
          held      = 1'b1;
          held_data = dump_data;
          held_idx  = dump_idx;
        end
      end
      tick();
    end
    dump_ready = 1'b0;
  endtask

  task automatic bp_run(input logic [31:0] base, input int unsigned k);
    int unsigned en;
    load_pc(base);
    bp_addr = base + 32'(4 * k);
    bp_en   = 1'b1;
    send(RUN, '0);
    run_until_halt(64, en);
    exp_cnt += 32'(k);
    chk("bp_en_cycles", 32'(en), 32'(k));
    chk("bp_pc", pc, bp_addr);
    chkb("bp_hit_set", bp_hit, 1'b1);
    chkb("bp_cpu_en", cpu_en, 1'b0);
    send(RUN, '0);
    chkb("bp_hit_clr", bp_hit, 1'b0);
    tick();
    chk("bp_resume_pc", pc, bp_addr + 32'd4);
    chkb("bp_resume_run", halted, 1'b0);
    send(HALT, '0);
    exp_cnt += 32'd2;
    chk("bp_cnt", cycle_cnt, exp_cnt);
    bp_en = 1'b0;
  endtask

  initial begin
    int unsigned en, got, n;
    logic [31:0] base, pc0;

    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
    bp_en = 1'b0; bp_addr = '0; dump_ready = 1'b0; pc_ld = 1'b0; pc_ld_val = '0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = '0; regs[1] = 32'h1111_1111; regs[31] = 32'hDEAD_BEEF;

    // Reset values
    repeat (3) tick();
    chkb("rst_halted", halted, 1'b0);
    chkb("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chkb("rst_dump_valid", dump_valid, 1'b0);
    chk("rst_dump_idx", 32'(dump_idx), 32'd0);
    chk("rst_dump_data", dump_data, 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chkb("rst_bp_hit", bp_hit, 1'b0);
    chkb("rst_cmd_err", cmd_err, 1'b0);

    // Free run out of reset, then halt
    rst_n = 1'b0;
    chkb("run_first_cpu_en", cpu_en, 1'b1);
    repeat (10) tick();
    chk("run_cnt10", cycle_cnt, 32'd10);
    send(HALT, '0);
    exp_cnt = 32'd11;
    chkb("halt_halted", halted, 1'b1);
    chkb("halt_cpu_en", cpu_en, 1'b0);
    repeat (3) tick();
    chk("halt_cnt_frozen", cycle_cnt, exp_cnt);

    // Step 3, random steps, step 0
    pc0 = pc;
    send(STEP, 16'd3);
    run_until_halt(64, en);
    exp_cnt += 32'd3;
    chk("step3_en", 32'(en), 32'd3);
    chk("step3_cnt", cycle_cnt, exp_cnt);
    chk("step3_pc", pc, pc0 + 32'd12);
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 20);
      pc0 = pc;
      send(STEP, STEP_W'(n));
      run_until_halt(64, en);
      exp_cnt += 32'(n);
      chk("stepN_en", 32'(en), 32'(n));
      chk("stepN_pc", pc, pc0 + 32'(4 * n));
    end
    chk("stepN_cnt", cycle_cnt, exp_cnt);
    send(STEP, '0);
    chkb("step0_cpu_en", cpu_en, 1'b0);
    repeat (3) tick();
    chkb("step0_halted", halted, 1'b1);
    chk("step0_cnt", cycle_cnt, exp_cnt);

    // Breakpoints: directed 0x0..0xC, then random base/distance
    bp_run(32'h0, 3);
    for (int r = 0; r < 2; r++) begin
      base = $urandom & 32'hFFFF_FF00;
      bp_run(base, $urandom_range(1, 15));
    end

    // Breakpoint cuts a step short, then a step resumes past it
    base = $urandom & 32'hFFFF_FF00;
    load_pc(base);
    bp_addr = base + 32'd8;
    bp_en = 1'b1;
    send(STEP, 16'd5);
    run_until_halt(64, en);
    exp_cnt += 32'd2;
    chk("stepbp_en", 32'(en), 32'd2);
    chkb("stepbp_hit", bp_hit, 1'b1);
    send(STEP, 16'd3);
    chkb("stepbp_clr", bp_hit, 1'b0);
    run_until_halt(64, en);
    exp_cnt += 32'd3;
    chk("stepbp_resume_en", 32'(en), 32'd3);
    chk("stepbp_pc", pc, base + 32'd20);
    bp_en = 1'b0;

    // Full dump with toggling ready
    send(DUMP, '0);
    chkb("dump_not_valid_yet", dump_valid, 1'b0);
    chkb("dump_ready_low", cmd_ready, 1'b0);
    chkb("dump_not_halted", halted, 1'b0);
    tick();
    chkb("dump_word0_valid", dump_valid, 1'b1);
    chk("dump_word0_idx", 32'(dump_idx), 32'd0);
    dump_words(1'b0, 32, got);
    chk("dump_count", 32'(got), 32'd32);
    chkb("dump_done_halted", halted, 1'b1);
    chkb("dump_done_valid", dump_valid, 1'b0);
    chk("dump_cnt", cycle_cnt, exp_cnt);

    // Illegal commands while running
    send(RUN, '0);
    send(DUMP, '0);
    chkb("run_dump_err", cmd_err, 1'b1);
    chkb("run_dump_state", halted, 1'b0);
    chkb("run_dump_no_dump", dump_valid, 1'b0);
    tick();
    chkb("run_err_pulse", cmd_err, 1'b0);
    send(STEP, 16'd4);
    chkb("run_step_err", cmd_err, 1'b1);
    send(HALT, '0);
    exp_cnt += 32'd4;
    chkb("run_halt", halted, 1'b1);
    chk("run_err_cnt", cycle_cnt, exp_cnt);

    // Abort a step with HALT on its third enabled cycle
    send(STEP, 16'd5);
    send(RUN, '0);
    chkb("step_run_err", cmd_err, 1'b1);
    tick();
    send(HALT, '0);
    exp_cnt += 32'd3;
    chkb("abort_halted", halted, 1'b1);
    chk("abort_cnt", cycle_cnt, exp_cnt);
    tick();
    chk("abort_cnt_frozen", cycle_cnt, exp_cnt);

    // Reset in the middle of a dump, with word 7 on the bus
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    send(DUMP, '0);
    tick();
    dump_words(1'b1, 7, got);
    chk("mid_count", 32'(got), 32'd7);
    tick();
    chkb("mid_word7_valid", dump_valid, 1'b1);
    chk("mid_word7_idx", 32'(dump_idx), 32'd7);
    #2 rst_n = 1'b1;
    #1;
    chkb("mid_rst_valid", dump_valid, 1'b0);
    chk("mid_rst_idx", 32'(dump_idx), 32'd0);
    chkb("mid_rst_run", halted, 1'b0);
    chkb("mid_rst_ready", cmd_ready, 1'b1);
    chk("mid_rst_cnt", cycle_cnt, 32'd0);
    tick();
    rst_n = 1'b0;
    repeat (5) tick();
    chk("post_rst_cnt", cycle_cnt, 32'd5);
    chk("post_rst_pc", pc, 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_dbg_ctrl.md
Name: sm_dbg_ctrl

Overview:
Run-control and debug sequencer for the pipelined schoolMIPS core. Drives the core's clock-enable to run, halt, or single/multi-step it. Stops the core on a fetch-address breakpoint. While the core is halted, it walks the register-file debug read port and streams all 32 registers out over a valid/ready interface. Sits between the top level and the core's clkEnable / regAddr / regData / imAddr signals.

Parameters:
STEP_W, 16, width of step-count argument and internal step counter
RUN_ON_RESET, 1, 1 = leave reset in RUN, 0 = leave reset in HALT

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge clk
cmd_op  in  2  command: 00 RUN, 01 HALT, 10 STEP, 11 DUMP
cmd_arg  in  STEP_W  step count for STEP; ignored for other ops
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint fetch address
im_addr  in  32  core fetch PC (imAddr)
cpu_en  out  1  core clock enable (combinational from state)
reg_addr  out  5  register-file debug read address
reg_data  in  32  register-file debug read data, valid same cycle as reg_addr
dump_valid  out  1  dump word valid
dump_ready  in  1  dump consumer ready
dump_idx  out  5  register index of dump_data
dump_data  out  32  register value
halted  out  1  state == HALT
bp_hit  out  1  sticky breakpoint flag
cmd_err  out  1  one-cycle pulse on illegal command
cycle_cnt  out  32  count of cycles with cpu_en=1

Behaviour:
- States: HALT, RUN, STEP, DUMP_RD, DUMP_WAIT.
- Reset state is RUN if RUN_ON_RESET=1, else HALT.
- Reset values: step_left=0, bp_skip=0, bp_hit=0, cmd_err=0, cycle_cnt=0, dump_valid=0, dump_idx=0, dump_data=0, reg_addr=0.
- Reset takes effect at any point, including mid-step or mid-dump; no partial state survives.
- bp_match = bp_en & (im_addr == bp_addr) & ~bp_skip.
- cpu_en = (state==RUN | state==STEP) & ~bp_match. A matching PC is never clocked past: the core freezes with that instruction in fetch.
- bp_skip:
  - Set on every transition into RUN or STEP, so a resume from a breakpoint PC advances past it.
  - Cleared after the first cycle with cpu_en=1.
- Breakpoint hit: in RUN or STEP, a cycle with bp_match moves the state to HALT at the next edge and sets bp_hit. bp_hit clears on acceptance of RUN or STEP.
- cycle_cnt increments on every cycle with cpu_en=1 and wraps 0xFFFFFFFF -> 0.
- cmd_ready = 1 in HALT, RUN and STEP; 0 in DUMP_*.
- HALT state:
  - RUN -> RUN.
  - STEP with arg N>0: step_left=N, go to STEP.
  - STEP with N=0: accepted, stays in HALT, no cpu_en.
  - DUMP: dump_idx=0, go to DUMP_RD.
  - HALT: no-op.
- RUN state:
  - HALT -> HALT. cpu_en is still 1 in the accept cycle (counted); it is 0 from the next cycle.
  - RUN: no-op.
  - STEP or DUMP: dropped, cmd_err pulses.
- STEP state:
  - Each cpu_en=1 cycle decrements step_left. When step_left==1 and cpu_en=1, go to HALT. Exactly N enabled cycles are issued.
  - HALT aborts to HALT.
  - RUN or STEP: dropped, cmd_err pulses.
  - DUMP: cmd_err pulses.
- If a breakpoint hit and step completion coincide, the state goes to HALT and bp_hit is set.
- DUMP_RD: reg_addr=dump_idx; dump_data<=reg_data; dump_valid<=1; go to DUMP_WAIT.
- DUMP_WAIT:
  - dump_data, dump_idx and dump_valid are held stable until dump_ready.
  - On dump_valid&dump_ready: dump_valid<=0. If dump_idx==31, go to HALT; else dump_idx++ and go to DUMP_RD.
  - One word per 2 cycles at most. Word 0 appears 2 cycles after DUMP is accepted.
- cpu_en = 0 throughout DUMP; halted = 1 only in HALT.

Test Plan:
- Reset with RUN_ON_RESET=1, bp_en=0 -> cpu_en=1 in the first cycle after reset release; cycle_cnt=10 after 10 cycles. Issue HALT -> cpu_en=0 from the next cycle; cycle_cnt frozen at 11.
- From HALT, STEP cmd_arg=3 -> exactly 3 cycles with cpu_en=1, then halted=1 and cycle_cnt advanced by 3. STEP cmd_arg=0 -> no cpu_en, halted stays 1.
- RUN with bp_en=1, bp_addr=0x0000000C, PC sequence 0,4,8,C -> cpu_en=0 when im_addr=0xC, halted=1, bp_hit=1. Re-issue RUN -> one enabled cycle past 0xC, bp_hit=0.
- Preload regs r1=0x11111111 and r31=0xDEADBEEF, halt, DUMP with dump_ready toggling 1/0 -> 32 words, indices 0..31, values match. dump_data is held while dump_ready=0. Returns to HALT; cmd_ready=0 during the dump.
- In RUN, issue DUMP -> cmd_err pulses for 1 cycle, state stays RUN. In STEP (arg=5), issue HALT after 2 cycles -> halted, cycle_cnt advanced by exactly 3 (accept cycle counted).
- Assert reset mid-dump at word 7 -> dump_valid=0 and dump_idx=0 immediately; state returns to the RUN_ON_RESET state.
